frame_fifo: RTL



---
 rtl/frame_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/frame_fifo.sv
// Single-clock data buffer with stream (plain FIFO) and frame (fill, lock, drain) modes.
// All flags, level and pointers are registered; read data has one cycle of latency.
module frame_fifo #(
   parameter int unsigned data_bit_width   = 12,
   parameter int unsigned data_bit_depth   = 10,
   parameter int unsigned data_depth       = 1000,
   parameter int unsigned almost_full_thr  = 900,
   parameter int unsigned almost_empty_thr = 100
) (
   input  logic                      clk_100M,
   input  logic                      rst,
   input  logic                      mode,
   input  logic                      wr_en,
   input  logic [data_bit_width-1:0] data_fifo_in,
   input  logic                      rd_en,
   output logic [data_bit_width-1:0] data_fifo_out,
   output logic                      rd_valid,
   output logic                      wr_full,
   output logic                      rd_empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [data_bit_depth:0]   level,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      clr_err,
   output logic                      frame_done
);

   localparam int unsigned LW = data_bit_depth + 1;
   localparam int unsigned AW = data_bit_depth;
   localparam logic [LW-1:0] DEPTH_L = LW'(data_depth);
   localparam logic [LW-1:0] AF_L    = LW'(almost_full_thr);
   localparam logic [LW-1:0] AE_L    = LW'(almost_empty_thr);
   localparam logic [AW-1:0] LAST_P  = AW'(data_depth - 1);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                    state, state_nx;
   logic                      mode_q, mode_nx;
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [LW-1:0]             level_nx;
   logic                      wr_acc, rd_acc;
   logic                      wr_full_nx, rd_empty_nx, done_nx;
   logic [data_bit_width-1:0] mem [0:(2**data_bit_depth)-1];

   always_comb begin
      wr_acc      = wr_en & ~wr_full;
      rd_acc      = rd_en & ~rd_empty;
      level_nx    = level;
      mode_nx     = mode_q;
      state_nx    = state;
      done_nx     = 1'b0;
      wr_full_nx  = 1'b0;
      rd_empty_nx = 1'b1;

      if (wr_acc && !rd_acc)
         level_nx = level + 1'b1;
      else if (rd_acc && !wr_acc)
         level_nx = level - 1'b1;

      // mode only switches on an idle, empty buffer so a frame is never split
      if (level == '0 && !wr_acc)
         mode_nx = mode;

      if (!mode_nx) begin
         state_nx = FILL;
      end else begin
         case (state)
            FILL:  if (wr_acc && level_nx == DEPTH_L) begin
                      state_nx = DRAIN;
                      done_nx  = 1'b1;
                   end
            DRAIN: if (rd_acc && level_nx == '0)
                      state_nx = FILL;
            default: state_nx = FILL;
         endcase
      end

      if (mode_nx) begin
         wr_full_nx  = (state_nx == DRAIN);
         rd_empty_nx = (state_nx == FILL);
      end else begin
         wr_full_nx  = (level_nx == DEPTH_L);
         rd_empty_nx = (level_nx == '0);
      end
   end

   always_ff @(posedge clk_100M) begin
      if (wr_acc)
         mem[wr_ptr] <= data_fifo_in;
   end

   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         state         <= FILL;
         mode_q        <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         wr_full       <= 1'b0;
         rd_empty      <= 1'b1;
         almost_full   <= 1'b0;
         almost_empty  <= 1'b1;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
         rd_valid      <= 1'b0;
         frame_done    <= 1'b0;
         data_fifo_out <= '0;
      end else begin
         state        <= state_nx;
         mode_q       <= mode_nx;
         level        <= level_nx;
         wr_full      <= wr_full_nx;
         rd_empty     <= rd_empty_nx;
         almost_full  <= (level_nx >= AF_L);
         almost_empty <= (level_nx <= AE_L);
         frame_done   <= done_nx;
         rd_valid     <= rd_acc;
         overflow     <= (overflow & ~clr_err) | (wr_en & wr_full);
         underflow    <= (underflow & ~clr_err) | (rd_en & rd_empty);
         if (wr_acc)
            wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr        <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            data_fifo_out <= mem[rd_ptr];
         end
      end
   end

endmodule
